// File: rtl/axis_pkt_gen.sv
// AXI-Stream packet source: programmable-length packets of incrementing data,
// single-shot or continuous with a fixed idle gap between packets.
module axis_pkt_gen #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned LEN_W    = 8,
  parameter int unsigned IDLE_GAP = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  pkt_len,
  input  logic [DATA_W-1:0] seed,
  input  logic              cont_mode,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              done,
  output logic [15:0]       pkt_cnt
);

  localparam int unsigned GapW = (IDLE_GAP > 1) ? $clog2(IDLE_GAP + 1) : 1;

  typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    beat_q, beat_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                last_q, last_d;
  logic                done_q, done_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [GapW-1:0]     gap_q, gap_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      len_q   <= '0;
      beat_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      data_q  <= data_d;
      last_q  <= last_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
    end
  end

  // data_q always holds the beat on the bus; since the next packet's seed is
  // seed+len, a continuing train simply keeps incrementing it.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    beat_d  = beat_q;
    data_d  = data_q;
    last_d  = last_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    case (state_q)
      StIdle: begin
        if (start && (pkt_len != '0)) begin
          state_d = StSend;
          len_d   = pkt_len;
          data_d  = seed;
          beat_d  = '0;
          last_d  = (pkt_len == LEN_W'(1));
        end
      end
      StSend: begin
        if (m_ready) begin
          data_d = data_q + 1'b1;
          if (last_q) begin
            done_d = 1'b1;
            cnt_d  = cnt_q + 1'b1;
            beat_d = '0;
            last_d = (len_q == LEN_W'(1));
            if (!cont_mode) begin
              state_d = StIdle;
            end else if (IDLE_GAP == 0) begin
              state_d = StSend;
            end else begin
              state_d = StGap;
              gap_d   = '0;
            end
          end else begin
            beat_d = beat_q + 1'b1;
            last_d = ((beat_q + 1'b1) == (len_q - 1'b1));
          end
        end
      end
      StGap: begin
        if (gap_q == GapW'(IDLE_GAP - 1)) begin
          state_d = StSend;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode registered state only; no input-to-output paths.
  always_comb begin
    m_valid = (state_q == StSend);
    m_last  = (state_q == StSend) && last_q;
    busy    = (state_q != StIdle);
    m_data  = data_q;
    done    = done_q;
    pkt_cnt = cnt_q;
  end

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Bench for axis_pkt_gen: vector table of single packets plus hand-written
// sequences; a scoreboard queue checks every presented beat.
module tb_axis_pkt_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  pkt_len;
  logic [7:0]  seed;
  logic        cont_mode;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic        busy;
  logic        done;
  logic [15:0] pkt_cnt;

  always #5 clk = ~clk;

  axis_pkt_gen #(
    .DATA_W  (8),
    .LEN_W   (8),
    .IDLE_GAP(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .pkt_len  (pkt_len),
    .seed     (seed),
    .cont_mode(cont_mode),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_last   (m_last),
    .busy     (busy),
    .done     (done),
    .pkt_cnt  (pkt_cnt)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  typedef struct {
    logic [7:0] len;
    logic [7:0] seed;
    logic [7:0] rdy;   // m_ready pattern, bit i used on cycle i mod 8
  } vec_t;

  beat_t exp_q[$];
  vec_t  vecs[5];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    done_cnt = 0;
  int    exp_cnt  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_pkt(input int len, input logic [7:0] s);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = s + 8'(i);
      b.last = (i == len - 1);
      exp_q.push_back(b);
    end
  endtask

  // Scoreboard: every presented beat must match the head; it pops on handshake.
  always @(negedge clk) begin
    if (rst) begin
      if (done) done_cnt++;
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got data 0x%0h, expected no beat", m_data);
        end else begin
          chk("beat_data", 32'(m_data), 32'(exp_q[0].data));
          chk("beat_last", 32'(m_last), 32'(exp_q[0].last));
          if (m_ready) void'(exp_q.pop_front());
        end
      end else begin
        chk("last_without_valid", 32'(m_last), 32'(0));
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int   cyc;
    int   exp_cyc;
    int   ones;
    logic got;
    logic busy_at;
    logic valid_at;
    push_pkt(int'(v.len), v.seed);
    ones    = 0;
    exp_cyc = 0;
    for (int j = 0; j < 200 && ones < int'(v.len); j++) begin
      if (v.rdy[j % 8]) ones++;
      exp_cyc = j + 1;
    end
    pkt_len = v.len;
    seed    = v.seed;
    start   = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'(1));
    chk("start_valid", 32'(m_valid), 32'(1));
    cyc      = 0;
    got      = 1'b0;
    busy_at  = 1'b1;
    valid_at = 1'b1;
    while (!got && cyc < 200) begin
      m_ready = v.rdy[cyc % 8];
      @(negedge clk);
      if (done) begin
        got      = 1'b1;
        busy_at  = busy;
        valid_at = m_valid;
      end else begin
        cyc++;
      end
      @(posedge clk);
      #1;
    end
    m_ready = 1'b0;
    exp_cnt++;
    chk("done_seen", 32'(got), 32'(1));
    chk("pkt_cycles", 32'(cyc), 32'(exp_cyc));
    chk("busy_at_done", 32'(busy_at), 32'(0));
    chk("valid_at_done", 32'(valid_at), 32'(0));
    chk("done_pulse_width", 32'(done), 32'(0));
    chk("pkt_cnt", 32'(pkt_cnt), 32'(exp_cnt));
    chk("queue_drained", 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   base;
    int   pkt;
    int   pos;
    int   cyc;
    logic got;
    vec_t v;

    vecs[0] = '{8'd4, 8'h10, 8'hFF};  // plain packet, full throughput
    vecs[1] = '{8'd5, 8'h00, 8'hD9};  // ready 1,0,0,1,1,0,1,1
    vecs[2] = '{8'd4, 8'hFE, 8'hFF};  // data wrap
    vecs[3] = '{8'd1, 8'h55, 8'hAA};  // single beat, first cycle stalled
    vecs[4] = '{8'd3, 8'h7F, 8'h55};  // alternating ready

    rst       = 1'b0;
    start     = 1'b0;
    cont_mode = 1'b0;
    m_ready   = 1'b0;
    pkt_len   = '0;
    seed      = '0;
    #1;
    chk("rst_data", 32'(m_data), 32'(0));
    chk("rst_valid", 32'(m_valid), 32'(0));
    chk("rst_last", 32'(m_last), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_pkt_cnt", 32'(pkt_cnt), 32'(0));
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    tick();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Zero length start is ignored.
    base    = done_cnt;
    pkt_len = 8'd0;
    seed    = 8'h33;
    start   = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) begin
      chk("len0_busy", 32'(busy), 32'(0));
      chk("len0_valid", 32'(m_valid), 32'(0));
      tick();
    end
    chk("len0_no_done", 32'(done_cnt - base), 32'(0));
    chk("len0_pkt_cnt", 32'(pkt_cnt), 32'(exp_cnt));

    // Second start during SEND must not disturb the running packet.
    push_pkt(6, 8'h20);
    pkt_len = 8'd6;
    seed    = 8'h20;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    tick();
    pkt_len = 8'd2;
    seed    = 8'h99;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    m_ready = 1'b1;
    got     = 1'b0;
    cyc     = 0;
    while (!got && cyc < 100) begin
      @(negedge clk);
      if (done) got = 1'b1;
      cyc++;
      @(posedge clk);
      #1;
    end
    m_ready = 1'b0;
    exp_cnt++;
    chk("restart_done", 32'(got), 32'(1));
    chk("restart_queue", 32'(exp_q.size()), 32'(0));
    chk("restart_pkt_cnt", 32'(pkt_cnt), 32'(exp_cnt));
    tick();
    chk("restart_idle", 32'(busy), 32'(0));

    // Continuous mode: 3 beats, 2 idle cycles, cont_mode cleared during the 2nd gap.
    base = done_cnt;
    push_pkt(3, 8'd0);
    push_pkt(3, 8'd3);
    push_pkt(3, 8'd6);
    pkt_len   = 8'd3;
    seed      = 8'd0;
    cont_mode = 1'b1;
    m_ready   = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t < 18; t++) begin
      @(negedge clk);
      pkt = t / 5;
      pos = t % 5;
      chk("cont_valid", 32'(m_valid), 32'(pkt < 3 && pos < 3));
      chk("cont_done", 32'(done), 32'(pkt < 3 && pos == 3));
      chk("cont_busy", 32'(busy), 32'(t < 13));
      @(posedge clk);
      #1;
      if (t == 8) cont_mode = 1'b0;
    end
    m_ready = 1'b0;
    exp_cnt += 3;
    chk("cont_done_count", 32'(done_cnt - base), 32'(3));
    chk("cont_pkt_cnt", 32'(pkt_cnt), 32'(exp_cnt));
    chk("cont_queue", 32'(exp_q.size()), 32'(0));

    // Asynchronous reset on beat 2 of an 8-beat packet.
    push_pkt(8, 8'd0);
    pkt_len = 8'd8;
    seed    = 8'd0;
    m_ready = 1'b1;
    start   = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("pre_rst_data", 32'(m_data), 32'(2));
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", 32'(m_valid), 32'(0));
    chk("arst_last", 32'(m_last), 32'(0));
    chk("arst_busy", 32'(busy), 32'(0));
    chk("arst_pkt_cnt", 32'(pkt_cnt), 32'(0));
    chk("arst_data", 32'(m_data), 32'(0));
    exp_q.delete();
    exp_cnt = 0;
    base    = done_cnt;
    m_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    chk("arst_no_done", 32'(done_cnt - base), 32'(0));
    v = '{8'd2, 8'h40, 8'hFF};
    run_vec(v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
